// File: rtl/fifo_ctrl.sv
// fifo_ctrl: synchronous FIFO controller wrapped around an external dual-port
// RAM that has a 1-cycle registered read port. The RAM's read-data register is
// used as the show-ahead output stage. Total capacity is DEPTH+1 words: DEPTH
// in the RAM and one in that output register.
//
// Ports:
//   clk_i, srst_i         clock, synchronous active-high reset
//   wr_valid_i/wr_data_i  write stream in; wr_ready_o accepts a word
//   rd_valid_o/rd_data_o  show-ahead read stream out; rd_ready_i pops the head
//   usedw_o               words held (RAM plus output stage)
//   full_o, empty_o       !wr_ready_o, !rd_valid_o
//   ram_*                 drive the RAM; ram_rd_data_i is its registered output
module fifo_ctrl #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              wr_valid_i,
  input  logic [DWIDTH-1:0] wr_data_i,
  output logic              wr_ready_o,
  output logic              rd_valid_o,
  output logic [DWIDTH-1:0] rd_data_o,
  input  logic              rd_ready_i,
  output logic [AWIDTH:0]   usedw_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              ram_wr_en_o,
  output logic [AWIDTH-1:0] ram_wr_addr_o,
  output logic [DWIDTH-1:0] ram_wr_data_o,
  output logic              ram_rd_en_o,
  output logic [AWIDTH-1:0] ram_rd_addr_o,
  input  logic [DWIDTH-1:0] ram_rd_data_i
);

  localparam int              DEPTH   = 2**AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH+1)'(DEPTH);

  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   ram_cnt_q, ram_cnt_d;
  logic              out_valid_q, out_valid_d;

  logic wr_ready;
  logic wr_fire;
  logic fetch;
  logic pop;

  always_comb begin
    wr_ready = (ram_cnt_q != DEPTH_C);
    // Reset wins over any transfer, so nothing reaches the RAM in that cycle.
    wr_fire  = wr_valid_i && wr_ready && !srst_i;
    pop      = out_valid_q && rd_ready_i;
    // Refill the output register whenever it is empty or being consumed. The
    // count is registered, so a word written this cycle is never fetched now.
    fetch    = (ram_cnt_q != '0) && (!out_valid_q || rd_ready_i) && !srst_i;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_cnt_d   = ram_cnt_q;
    out_valid_d = out_valid_q;

    if (wr_fire) wr_ptr_d = wr_ptr_q + AWIDTH'(1);
    if (fetch)   rd_ptr_d = rd_ptr_q + AWIDTH'(1);

    case ({wr_fire, fetch})
      2'b10:   ram_cnt_d = ram_cnt_q + (AWIDTH+1)'(1);
      2'b01:   ram_cnt_d = ram_cnt_q - (AWIDTH+1)'(1);
      default: ram_cnt_d = ram_cnt_q;
    endcase

    if (fetch)    out_valid_d = 1'b1;
    else if (pop) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_cnt_q   <= ram_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  // The RAM holds its read register when ram_rd_en_o is low, which keeps
  // rd_data_o stable under back-pressure with no extra storage here.
  assign wr_ready_o    = wr_ready;
  assign full_o        = !wr_ready;
  assign rd_valid_o    = out_valid_q;
  assign empty_o       = !out_valid_q;
  assign rd_data_o     = ram_rd_data_i;
  assign usedw_o       = ram_cnt_q + (AWIDTH+1)'(out_valid_q);
  assign ram_wr_en_o   = wr_fire;
  assign ram_wr_addr_o = wr_ptr_q;
  assign ram_wr_data_o = wr_data_i;
  assign ram_rd_en_o   = fetch;
  assign ram_rd_addr_o = rd_ptr_q;

endmodule
